// File: rtl/fetch.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one
// instruction-memory read in flight, queues returned words with their
// addresses in a small prefetch buffer and presents the head to decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic [31:0] BrPC,
  output logic [31:0] inst,
  output logic [31:0] pc_o,
  output logic        inst_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fpc_q, fpc_d;
  logic [31:0]        tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        buf_inst_q [DEPTH];
  logic [31:0]        buf_inst_d [DEPTH];
  logic [31:0]        buf_pc_q   [DEPTH];
  logic [31:0]        buf_pc_d   [DEPTH];

  logic               in_wait;
  logic               pop;
  logic               push;
  logic               accept;
  logic [CNT_W:0]     occ;

  assign imem_addr  = fpc_q;
  assign inst_valid = (cnt_q != '0);
  assign inst       = buf_inst_q[rd_ptr_q];
  assign pc_o       = buf_pc_q[rd_ptr_q];

  // Request/accept decision, redirect handling, buffer push/pop and FSM next state.
  // A new read is only issued when the word it will return is guaranteed a slot:
  // the occupancy counts the word still owed by the outstanding read and credits
  // the head leaving this cycle, so a full buffer can never be pushed.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;

    in_wait = (state_q == WAIT);
    pop     = inst_valid && !stall && !Branch;
    push    = in_wait && imem_rvalid && !Branch;
    occ     = {1'b0, cnt_q} + (CNT_W + 1)'(in_wait) - (CNT_W + 1)'(pop);
    imem_rd = !rst && !Branch && (occ < DEPTH_V) &&
              ((state_q == IDLE) || (in_wait && imem_rvalid));
    accept  = imem_rd && imem_rdy;

    if (Branch) begin
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
      fpc_d    = BrPC;
      case (state_q)
        WAIT:    state_d = imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = WAIT;
        WAIT:    if (imem_rvalid) state_d = accept ? WAIT : IDLE;
        DROP:    if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (accept) begin
        fpc_d = fpc_q + PC_INC;
        tag_d = fpc_q;
      end

      if (push) begin
        buf_inst_d[wr_ptr_q] = imem_rdata;
        buf_pc_d[wr_ptr_q]   = tag_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // All fetch state, including the buffer contents, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      tag_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch front end: a fixed-latency table walk
// through start-up, stall and redirect, hand-written redirect and reset
// sequences, and a randomized run against a sequential-PC scoreboard.
module tb_fetch;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        imem_rd;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch;
   logic [31:0] br_pc;
   logic [31:0] inst;
   logic [31:0] pc_o;
   logic        inst_valid;

   int          checks;
   int          passes;

   logic        pend;
   int          pendLeft;
   logic [31:0] pendAddr;
   int          lat;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] brpc;
      logic        expRd;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;

   vec_t vecs [14];

   fetch #(
      .RESET_PC(32'h0000_0000),
      .PC_INC  (32'd1),
      .DEPTH   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_rd    (imem_rd),
      .imem_addr  (imem_addr),
      .imem_rdy   (imem_rdy),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .stall      (stall),
      .Branch     (branch),
      .BrPC       (br_pc),
      .inst       (inst),
      .pc_o       (pc_o),
      .inst_valid (inst_valid)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a sequence never reaches its summary.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic s, input logic b, input logic [31:0] bp,
                                  input logic rd, input logic [31:0] addr,
                                  input logic v, input logic [31:0] pc);
      vec_t r;
      r.stall    = s;
      r.br       = b;
      r.brpc     = bp;
      r.expRd    = rd;
      r.expAddr  = addr;
      r.expValid = v;
      r.expPc    = pc;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   // Drive one cycle's inputs on the falling edge; the memory model supplies the response.
   task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bp, input logic rdy);
      @(negedge clk);
      stall       = s;
      branch      = b;
      br_pc       = bp;
      imem_rdy    = rdy;
      imem_rvalid = pend && (pendLeft == 0);
      imem_rdata  = imem_rvalid ? (pendAddr ^ KEY) : 32'hDEAD_BEEF;
      #1;
   endtask

   // Cross the rising edge and update the memory model from what was accepted.
   task automatic advance();
      logic        acc;
      logic        rv;
      logic [31:0] a;
      acc = imem_rd && imem_rdy;
      rv  = imem_rvalid;
      a   = imem_addr;
      @(posedge clk);
      if (rv) pend = 1'b0;
      else if (pend && pendLeft > 0) pendLeft--;
      if (acc) begin
         pend     = 1'b1;
         pendLeft = lat - 1;
         pendAddr = a;
      end
   endtask

   // Hold reset for two cycles, check reset values, release just after a rising edge.
   task automatic doReset();
      rst         = 1'b1;
      stall       = 1'b0;
      branch      = 1'b0;
      br_pc       = 32'h0;
      imem_rdy    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      pend        = 1'b0;
      pendLeft    = 0;
      pendAddr    = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_rd",    32'(imem_rd),    32'h0);
      checkOutput("reset_valid", 32'(inst_valid), 32'h0);
      checkOutput("reset_inst",  inst,            32'h0);
      checkOutput("reset_pc",    pc_o,            32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Test sequence: table walk, redirect with read in flight, reset mid-flight, random run.
   initial begin
      logic        found;
      logic [31:0] expNext;
      int          pops;
      logic        rRdy;
      logic        rStall;
      logic        rBr;
      logic [31:0] rPc;

      checks = 0;
      passes = 0;
      lat    = 1;

      vecs[0]  = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0);
      vecs[1]  = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h1,  1'b0, 32'h0);
      vecs[2]  = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h2,  1'b1, 32'h0);
      vecs[3]  = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h3,  1'b1, 32'h1);
      vecs[4]  = mkVec(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h2);
      vecs[5]  = mkVec(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h2);
      vecs[6]  = mkVec(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h2);
      vecs[7]  = mkVec(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h2);
      vecs[8]  = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h2);
      vecs[9]  = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h5,  1'b1, 32'h3);
      vecs[10] = mkVec(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,  1'b1, 32'h4);
      vecs[11] = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0);
      vecs[12] = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h41, 1'b0, 32'h0);
      vecs[13] = mkVec(1'b0, 1'b0, 32'h0,  1'b1, 32'h42, 1'b1, 32'h40);

      // Single-cycle memory: start-up, 4-cycle stall, branch coinciding with a response.
      doReset();
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].brpc, 1'b1);
         checkOutput($sformatf("vec%0d_rd", i), 32'(imem_rd), 32'(vecs[i].expRd));
         if (vecs[i].expRd) checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d_pc", i), pc_o, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_inst", i), inst, vecs[i].expPc ^ KEY);
         end
         advance();
      end

      // Three-cycle memory: redirect while the read for address 5 is in flight.
      doReset();
      lat   = 3;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         if (imem_rd && imem_rdy && imem_addr == 32'h5) found = 1'b1;
         advance();
         if (found) break;
      end
      checkOutput("seen_addr5", 32'(found), 32'h1);
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
      checkOutput("br_rd", 32'(imem_rd), 32'h0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("drop1_rd", 32'(imem_rd), 32'h0);
      checkOutput("drop1_valid", 32'(inst_valid), 32'h0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("stale_rvalid", 32'(imem_rvalid), 32'h1);
      checkOutput("stale_rd", 32'(imem_rd), 32'h0);
      checkOutput("stale_valid", 32'(inst_valid), 32'h0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redir_rd", 32'(imem_rd), 32'h1);
      checkOutput("redir_addr", imem_addr, 32'h40);
      checkOutput("redir_valid", 32'(inst_valid), 32'h0);
      advance();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         checkOutput($sformatf("redir_wait%0d_valid", k), 32'(inst_valid), 32'h0);
         advance();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redir_resp_valid", 32'(inst_valid), 32'h0);
      checkOutput("redir_next_addr", imem_addr, 32'h41);
      checkOutput("redir_next_rd", 32'(imem_rd), 32'h1);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redir_head_valid", 32'(inst_valid), 32'h1);
      checkOutput("redir_head_pc", pc_o, 32'h40);
      checkOutput("redir_head_inst", inst, 32'h40 ^ KEY);
      advance();

      // Four-cycle memory with decode stalled: reset while a read is in flight.
      doReset();
      lat = 4;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
         advance();
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("pre_rst_valid", 32'(inst_valid), 32'h1);
      checkOutput("pre_rst_pc", pc_o, 32'h0);
      checkOutput("pre_rst_inst", inst, KEY);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 32'(inst_valid), 32'h0);
      checkOutput("mid_rst_inst", inst, 32'h0);
      checkOutput("mid_rst_pc", pc_o, 32'h0);
      checkOutput("mid_rst_rd", 32'(imem_rd), 32'h0);
      pend = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("restart_rd", 32'(imem_rd), 32'h1);
      checkOutput("restart_addr", imem_addr, 32'h0);
      checkOutput("restart_valid", 32'(inst_valid), 32'h0);
      advance();

      // Random readiness, latency, stalls and redirects against a sequential-PC scoreboard.
      doReset();
      expNext = 32'h0;
      pops    = 0;
      for (int n = 0; n < 1000; n++) begin
         lat    = int'($urandom_range(5, 1));
         rRdy   = ($urandom_range(3, 0) != 0);
         rStall = ($urandom_range(3, 0) == 0);
         rBr    = ($urandom_range(39, 0) == 0);
         rPc    = $urandom;
         applyStimulus(rStall, rBr, rPc, rRdy);
         if (imem_rd && imem_rdy) checkOutput("one_outstanding", 32'(pend && !imem_rvalid), 32'h0);
         if (rBr) begin
            expNext = rPc;
         end else if (inst_valid && !rStall) begin
            checkOutput("rand_pc", pc_o, expNext);
            checkOutput("rand_inst", inst, expNext ^ KEY);
            expNext = expNext + 32'd1;
            pops++;
         end
         advance();
      end
      checkOutput("rand_progress", 32'(pops > 100), 32'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
